// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle shared between the ALU arbiter and its requesters/ALU.
// slave = arbiter side, master = requester/ALU/consumer side.
interface alu_arbiter_if #(
    parameter int XLEN      = 32,
    parameter int ALU_SEL_W = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [1:0]           req0_aluop;
    logic [3:0]           req0_inst;
    logic [XLEN-1:0]      req0_a;
    logic [XLEN-1:0]      req0_b;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [1:0]           req1_aluop;
    logic [3:0]           req1_inst;
    logic [XLEN-1:0]      req1_a;
    logic [XLEN-1:0]      req1_b;

    logic [ALU_SEL_W-1:0] alu_ctl;
    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [XLEN-1:0]      alu_result;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_err;

    modport slave (
        input  req0_valid, req0_aluop, req0_inst, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_aluop, req1_inst, req1_a, req1_b,
        output req1_ready,
        output alu_ctl, alu_a, alu_b,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_aluop, req0_inst, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_aluop, req1_inst, req1_a, req1_b,
        input  req1_ready,
        input  alu_ctl, alu_a, alu_b,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/decoder for the shared EX ALU; ALU_ARB_ROUND_ROBIN_EN selects round-robin, else port 0 priority.
// Latency: grant at edge N, ALU driven in N+1, rsp_valid from N+2 (one op per 3 cycles).
// Backpressure: rsp_ready low parks the block in RESP with both request readies low.
module alu_arbiter #(
    parameter int XLEN      = 32,
    parameter int ALU_SEL_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = ALU_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] ALU_BNE  = ALU_SEL_W'(6);
    localparam logic [ALU_SEL_W-1:0] ALU_BLT  = ALU_SEL_W'(7);
    localparam logic [ALU_SEL_W-1:0] ALU_BGE  = ALU_SEL_W'(8);
    localparam logic [ALU_SEL_W-1:0] ALU_BLTU = ALU_SEL_W'(9);
    localparam logic [ALU_SEL_W-1:0] ALU_BGEU = ALU_SEL_W'(10);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e               state_q;
    logic [ALU_SEL_W-1:0] alu_ctl_q;
    logic [XLEN-1:0]      alu_a_q;
    logic [XLEN-1:0]      alu_b_q;
    logic                 id_q;
    logic                 err_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [XLEN-1:0]      rsp_result_q;
    logic                 rsp_err_q;

    logic                 any_vld;
    logic                 grant;
    logic                 win_id;
    logic [1:0]           win_aluop;
    logic [3:0]           win_inst;
    logic [XLEN-1:0]      win_a_d;
    logic [XLEN-1:0]      win_b_d;
    logic [ALU_SEL_W-1:0] dec_sel_d;
    logic                 dec_err_d;

    // Returns {err, select}; err forces select to 0.
    function automatic logic [ALU_SEL_W:0] decode(input logic [1:0] aluop, input logic [3:0] inst);
        logic [ALU_SEL_W-1:0] sel;
        logic                 err;
        sel = '0;
        err = 1'b0;
        case (aluop)
            2'b00: sel = ALU_ADD;
            2'b01: begin
                case (inst[2:0])
                    3'b000:  sel = ALU_SUB;
                    3'b001:  sel = ALU_BNE;
                    3'b100:  sel = ALU_BLT;
                    3'b101:  sel = ALU_BGE;
                    3'b110:  sel = ALU_BLTU;
                    3'b111:  sel = ALU_BGEU;
                    default: err = 1'b1;
                endcase
            end
            default: begin
                case (inst)
                    4'b0000: sel = ALU_ADD;
                    4'b1000: sel = ALU_SUB;
                    4'b0111: sel = ALU_AND;
                    4'b0110: sel = ALU_OR;
                    4'b0100: sel = ALU_XOR;
                    default: err = 1'b1;
                endcase
            end
        endcase
        return {err, sel};
    endfunction

    assign any_vld = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ptr_q;

    // On a tie the port that did not win last time goes next.
    assign win_id = (bus.req0_valid && bus.req1_valid) ? ~ptr_q : ~bus.req0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (grant) begin
            ptr_q <= win_id;
        end
    end
`else
    assign win_id = ~bus.req0_valid;
`endif

    // Readies are gated by rst_n so nothing can handshake while reset is held.
    assign grant          = rst_n && (state_q == IDLE) && any_vld;
    assign bus.req0_ready = grant && !win_id;
    assign bus.req1_ready = grant && win_id;

    assign win_aluop = win_id ? bus.req1_aluop : bus.req0_aluop;
    assign win_inst  = win_id ? bus.req1_inst  : bus.req0_inst;
    assign win_a_d   = win_id ? bus.req1_a     : bus.req0_a;
    assign win_b_d   = win_id ? bus.req1_b     : bus.req0_b;
    assign {dec_err_d, dec_sel_d} = decode(win_aluop, win_inst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_ctl_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        alu_ctl_q <= dec_sel_d;
                        alu_a_q   <= win_a_d;
                        alu_b_q   <= win_b_d;
                        id_q      <= win_id;
                        err_q     <= dec_err_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= bus.alu_result;
                    rsp_id_q     <= id_q;
                    rsp_err_q    <= err_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_ctl    = alu_ctl_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of grant, decode and response timing.
module tb_alu_arbiter;
    localparam int XLEN = 32;
    localparam int SW   = 4;

    localparam logic [SW-1:0] C_ADD  = 4'd1;
    localparam logic [SW-1:0] C_SUB  = 4'd2;
    localparam logic [SW-1:0] C_AND  = 4'd3;
    localparam logic [SW-1:0] C_OR   = 4'd4;
    localparam logic [SW-1:0] C_XOR  = 4'd5;
    localparam logic [SW-1:0] C_BNE  = 4'd6;
    localparam logic [SW-1:0] C_BLT  = 4'd7;
    localparam logic [SW-1:0] C_BGE  = 4'd8;
    localparam logic [SW-1:0] C_BLTU = 4'd9;
    localparam logic [SW-1:0] C_BGEU = 4'd10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(XLEN), .ALU_SEL_W(SW)) ifc ();
    alu_arbiter #(.XLEN(XLEN), .ALU_SEL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_w(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] alu_fn(input logic [SW-1:0] c, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (c)
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_XOR:   return a ^ b;
            C_BNE:   return XLEN'(a != b);
            C_BLT:   return XLEN'($signed(a) < $signed(b));
            C_BGE:   return XLEN'($signed(a) >= $signed(b));
            C_BLTU:  return XLEN'(a < b);
            C_BGEU:  return XLEN'(a >= b);
            default: return 32'hBAD0_0000;
        endcase
    endfunction

    assign ifc.alu_result = alu_fn(ifc.alu_ctl, ifc.alu_a, ifc.alu_b);

    function automatic logic [SW:0] ref_decode(input logic [1:0] op, input logic [3:0] inst);
        casez ({op, inst})
            6'b00????: return {1'b0, C_ADD};
            6'b01?000: return {1'b0, C_SUB};
            6'b01?001: return {1'b0, C_BNE};
            6'b01?100: return {1'b0, C_BLT};
            6'b01?101: return {1'b0, C_BGE};
            6'b01?110: return {1'b0, C_BLTU};
            6'b01?111: return {1'b0, C_BGEU};
            6'b1?0000: return {1'b0, C_ADD};
            6'b1?1000: return {1'b0, C_SUB};
            6'b1?0111: return {1'b0, C_AND};
            6'b1?0110: return {1'b0, C_OR};
            6'b1?0100: return {1'b0, C_XOR};
            default:   return {1'b1, {SW{1'b0}}};
        endcase
    endfunction

    // Model: an outstanding transaction and its age in cycles since the grant.
    bit              m_busy = 1'b0;
    int              m_age  = 0;
    bit              m_last = 1'b1;
    bit              m_id   = 1'b0;
    bit              m_err  = 1'b0;
    logic [SW-1:0]   m_ctl  = '0;
    logic [XLEN-1:0] m_a    = '0;
    logic [XLEN-1:0] m_b    = '0;
    logic [XLEN-1:0] m_res  = '0;

    always @(negedge clk) begin
        bit          e_r0, e_r1, w;
        logic [SW:0] d;
        if (!rst_n) begin
            check_w("rst_req0_ready", XLEN'(ifc.req0_ready), '0);
            check_w("rst_req1_ready", XLEN'(ifc.req1_ready), '0);
            check_w("rst_rsp_valid", XLEN'(ifc.rsp_valid), '0);
            check_w("rst_rsp_id", XLEN'(ifc.rsp_id), '0);
            check_w("rst_rsp_err", XLEN'(ifc.rsp_err), '0);
            check_w("rst_rsp_result", ifc.rsp_result, '0);
            check_w("rst_alu_ctl", XLEN'(ifc.alu_ctl), '0);
            check_w("rst_alu_a", ifc.alu_a, '0);
            check_w("rst_alu_b", ifc.alu_b, '0);
            m_busy = 1'b0;
            m_last = 1'b1;
            m_ctl  = '0;
            m_a    = '0;
            m_b    = '0;
        end else begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            w    = 1'b0;
            if (!m_busy && (ifc.req0_valid || ifc.req1_valid)) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                w = (ifc.req0_valid && ifc.req1_valid) ? !m_last : !ifc.req0_valid;
`else
                w = !ifc.req0_valid;
`endif
                e_r0 = !w;
                e_r1 = w;
            end
            check_w("req0_ready", XLEN'(ifc.req0_ready), XLEN'(e_r0));
            check_w("req1_ready", XLEN'(ifc.req1_ready), XLEN'(e_r1));
            check_w("alu_ctl", XLEN'(ifc.alu_ctl), XLEN'(m_ctl));
            check_w("alu_a", ifc.alu_a, m_a);
            check_w("alu_b", ifc.alu_b, m_b);
            check_w("rsp_valid", XLEN'(ifc.rsp_valid), XLEN'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                check_w("rsp_id", XLEN'(ifc.rsp_id), XLEN'(m_id));
                check_w("rsp_err", XLEN'(ifc.rsp_err), XLEN'(m_err));
                check_w("rsp_result", ifc.rsp_result, m_res);
            end
            if (m_busy) begin
                if (m_age >= 2) begin
                    if (ifc.rsp_ready) m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (e_r0 || e_r1) begin
                d      = w ? ref_decode(ifc.req1_aluop, ifc.req1_inst) : ref_decode(ifc.req0_aluop, ifc.req0_inst);
                m_ctl  = d[SW-1:0];
                m_err  = d[SW];
                m_a    = w ? ifc.req1_a : ifc.req0_a;
                m_b    = w ? ifc.req1_b : ifc.req0_b;
                m_res  = alu_fn(m_ctl, m_a, m_b);
                m_id   = w;
                m_busy = 1'b1;
                m_age  = 1;
                m_last = w;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic [1:0] op, input logic [3:0] inst,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (p == 0) begin
            ifc.req0_valid = 1'b1; ifc.req0_aluop = op; ifc.req0_inst = inst; ifc.req0_a = a; ifc.req0_b = b;
        end else begin
            ifc.req1_valid = 1'b1; ifc.req1_aluop = op; ifc.req1_inst = inst; ifc.req1_a = a; ifc.req1_b = b;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) ifc.req0_valid = 1'b0;
        else        ifc.req1_valid = 1'b0;
    endtask

    task automatic rand_port(input int p, input bit g);
        logic            v;
        logic [XLEN-1:0] a;
        v = (p == 0) ? ifc.req0_valid : ifc.req1_valid;
        if (v && !g) begin
            if ($urandom_range(0, 9) == 0) drop(p);
        end else if ($urandom_range(0, 2) == 0) begin
            a = $urandom;
            req(p, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), a,
                ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom));
        end else begin
            drop(p);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int              grants[$];
        int              exp_g[4];
        logic [XLEN-1:0] held;
        bit              g0, g1;

        ifc.req0_valid = 0; ifc.req0_aluop = 0; ifc.req0_inst = 0; ifc.req0_a = 0; ifc.req0_b = 0;
        ifc.req1_valid = 0; ifc.req1_aluop = 0; ifc.req1_inst = 0; ifc.req1_a = 0; ifc.req1_b = 0;
        ifc.rsp_ready  = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single ADD: 5 + 7 from port 0
        ifc.rsp_ready = 1'b1;
        req(0, 2'b10, 4'b0000, 5, 7);
        @(negedge clk); check_w("add_ready0", XLEN'(ifc.req0_ready), 1);
        step(); drop(0);
        @(negedge clk); check_w("add_ctl", XLEN'(ifc.alu_ctl), XLEN'(C_ADD));
        step();
        @(negedge clk);
        check_w("add_rsp_valid", XLEN'(ifc.rsp_valid), 1);
        check_w("add_result", ifc.rsp_result, 12);
        check_w("add_id", XLEN'(ifc.rsp_id), 0);
        check_w("add_err", XLEN'(ifc.rsp_err), 0);
        step();

        // Illegal decode then a legal SUB on port 1
        req(0, 2'b10, 4'b0001, 3, 4);
        step(); drop(0);
        @(negedge clk); check_w("ill_ctl", XLEN'(ifc.alu_ctl), 0);
        step();
        @(negedge clk);
        check_w("ill_rsp_valid", XLEN'(ifc.rsp_valid), 1);
        check_w("ill_err", XLEN'(ifc.rsp_err), 1);
        step();
        req(1, 2'b01, 4'b0000, 10, 3);
        step(); drop(1); step();
        @(negedge clk);
        check_w("sub_err", XLEN'(ifc.rsp_err), 0);
        check_w("sub_result", ifc.rsp_result, 7);
        check_w("sub_id", XLEN'(ifc.rsp_id), 1);
        step();

        // Back-pressure: BLTU 2 <u 9 on port 1, consumer stalls 5 cycles
        ifc.rsp_ready = 1'b0;
        req(1, 2'b01, 4'b1110, 2, 9);
        step(); drop(1); step();
        req(0, 2'b00, 4'b0000, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_w("bp_rsp_valid", XLEN'(ifc.rsp_valid), 1);
            check_w("bp_rsp_id", XLEN'(ifc.rsp_id), 1);
            check_w("bp_result", ifc.rsp_result, 1);
            check_w("bp_ready0", XLEN'(ifc.req0_ready), 0);
            check_w("bp_ready1", XLEN'(ifc.req1_ready), 0);
            step();
        end
        ifc.rsp_ready = 1'b1;
        @(negedge clk); check_w("bp_final_valid", XLEN'(ifc.rsp_valid), 1);
        step();
        @(negedge clk); check_w("bp_next_grant0", XLEN'(ifc.req0_ready), 1);
        step(); drop(0); step(); step();

        // Withdrawn request on port 1 while a response is pending
        ifc.rsp_ready = 1'b0;
        req(0, 2'b10, 4'b0110, 32'hF0, 32'h0F);
        step(); drop(0); step();
        req(1, 2'b00, 4'b0000, 8, 8);
        @(negedge clk); check_w("wd_ready1", XLEN'(ifc.req1_ready), 0);
        step(); drop(1); step();
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        check_w("wd_rsp_valid", XLEN'(ifc.rsp_valid), 1);
        check_w("wd_result", ifc.rsp_result, 32'hFF);
        check_w("wd_id", XLEN'(ifc.rsp_id), 0);
        step();
        @(negedge clk);
        check_w("wd_no_rsp", XLEN'(ifc.rsp_valid), 0);
        check_w("wd_no_grant1", XLEN'(ifc.req1_ready), 0);
        step();

        // Reset while the SUB is in ISSUE
        req(0, 2'b10, 4'b1000, 9, 4);
        step(); drop(0);
        rst_n = 1'b0;
        #1;
        check_w("rst_issue_ctl", XLEN'(ifc.alu_ctl), 0);
        check_w("rst_issue_a", ifc.alu_a, 0);
        check_w("rst_issue_valid", XLEN'(ifc.rsp_valid), 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check_w("rst_no_rsp", XLEN'(ifc.rsp_valid), 0);
            step();
        end

        // Tie fairness right after reset: both ports valid continuously
        req(0, 2'b00, 4'b0000, 100, 1);
        req(1, 2'b00, 4'b0000, 200, 2);
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (ifc.req0_ready) grants.push_back(0);
            if (ifc.req1_ready) grants.push_back(1);
            step();
        end
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        check_w("tie_grant_count", XLEN'(grants.size()), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_w($sformatf("tie_grant%0d", i), XLEN'(grants[i]), XLEN'(exp_g[i]));
        drop(0); drop(1);
        repeat (4) step();

        // Randomized traffic with occasional resets
        held = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g0 = ifc.req0_ready;
            g1 = ifc.req1_ready;
            step();
            rand_port(0, g0);
            rand_port(1, g1);
            ifc.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                held++;
            end
        end
        drop(0); drop(1);
        rst_n = 1'b1;
        ifc.rsp_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
